// File: rtl/writeback_regfile.sv
// Y86-64 SEQ write-back stage: destination decode, 15-entry register file, halt FSM and retire counter.
// Optional macro WB_BYPASS_EN forwards same-cycle commit data onto the read ports.
module writeback_regfile #(
  parameter int         DATA_W = 64,
  parameter int         NREG   = 15,
  parameter logic [3:0] RNONE  = 4'hF,
  parameter logic [3:0] RRSP   = 4'h4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic              halted,
  output logic [63:0]       retired
);

  localparam logic [3:0] IC_HALT   = 4'h0;
  localparam logic [3:0] IC_CMOVXX = 4'h2;
  localparam logic [3:0] IC_IRMOVQ = 4'h3;
  localparam logic [3:0] IC_MRMOVQ = 4'h5;
  localparam logic [3:0] IC_OPQ    = 4'h6;
  localparam logic [3:0] IC_CALL   = 4'h8;
  localparam logic [3:0] IC_RET    = 4'h9;
  localparam logic [3:0] IC_PUSHQ  = 4'hA;
  localparam logic [3:0] IC_POPQ   = 4'hB;
  localparam logic [3:0] NREG_ID   = 4'(NREG);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [NREG];
  logic              commit;
  logic              stop;

  always_comb begin
    dstE = RNONE;
    case (icode)
      IC_CMOVXX:                           dstE = cnd ? rB : RNONE;
      IC_IRMOVQ, IC_OPQ:                   dstE = rB;
      IC_CALL, IC_RET, IC_PUSHQ, IC_POPQ:  dstE = RRSP;
      default:                             dstE = RNONE;
    endcase
  end

  always_comb begin
    dstM = RNONE;
    case (icode)
      IC_MRMOVQ, IC_POPQ: dstM = rA;
      default:            dstM = RNONE;
    endcase
  end

  // Halt (icode 0) still commits and counts; icodes 12..15 only stop the machine.
  assign commit = wb_valid && (state == RUN) && (icode <= IC_POPQ);
  assign stop   = wb_valid && (state == RUN) && ((icode == IC_HALT) || (icode > IC_POPQ));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      if (commit)
        retired <= retired + 64'd1;
      if (stop) begin
        state  <= HALT;
        halted <= 1'b1;
      end
    end
  end

  // M port takes priority so popq %rsp leaves the popped value in %rsp.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst)
        regs[i] <= '0;
      else if (commit && (dstM == 4'(i)))
        regs[i] <= valM;
      else if (commit && (dstE == 4'(i)))
        regs[i] <= valE;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] id);
    if (id >= NREG_ID)
      return '0;
`ifdef WB_BYPASS_EN
    if (commit && (id == dstM))
      return valM;
    if (commit && (id == dstE))
      return valE;
`endif
    return regs[id];
  endfunction

  assign valA = read_port(srcA);
  assign valB = read_port(srcB);

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed-vector bench for writeback_regfile; expectations are queued by the stimulus and checked by a negedge monitor.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [3:0]  icode, rA, rB, srcA, srcB;
  logic        cnd;
  logic [63:0] valE, valM;
  logic [63:0] valA, valB;
  logic [3:0]  dstE, dstM;
  logic        halted;
  logic [63:0] retired;

  writeback_regfile dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .icode(icode), .rA(rA), .rB(rB),
    .cnd(cnd), .valE(valE), .valM(valM), .srcA(srcA), .srcB(srcB),
    .valA(valA), .valB(valB), .dstE(dstE), .dstM(dstM),
    .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam int S_VALA = 0, S_VALB = 1, S_DSTE = 2, S_DSTM = 3, S_HALT = 4, S_RET = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] value;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;

  task automatic expect_val(input string name, input int sel, input logic [63:0] value);
    exp_t e;
    e.name = name;
    e.sel = sel;
    e.value = value;
    q.push_back(e);
  endtask

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      S_VALA:  return valA;
      S_VALB:  return valB;
      S_DSTE:  return {60'd0, dstE};
      S_DSTM:  return {60'd0, dstM};
      S_HALT:  return {63'd0, halted};
      default: return retired;
    endcase
  endfunction

  // Monitor: drain everything queued during the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [63:0] act;
      e = q.pop_front();
      act = observe(e.sel);
      compared++;
      if (act !== e.value) begin
        mismatched++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, act, e.value, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [63:0] e, input logic [63:0] m);
    wb_valid = v; icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m;
  endtask

  initial begin
    rst = 1'b1; srcA = 4'hF; srcB = 4'hF;
    drive(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
    tick();

    // irmovq $0x1234, %rdx
    rst = 1'b0; srcA = 4'h0; srcB = 4'hF;
    drive(1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'd0);
    expect_val("reset_halted", S_HALT, 64'd0);
    expect_val("reset_retired", S_RET, 64'd0);
    expect_val("reset_reg0", S_VALA, 64'd0);
    expect_val("rnone_read", S_VALB, 64'd0);
    expect_val("irmovq_dstE", S_DSTE, 64'h2);
    expect_val("irmovq_dstM", S_DSTM, 64'hF);
    tick();

    // popq %rsp: E and M both target reg 4
    srcA = 4'h2;
    drive(1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'hBEEF);
    expect_val("irmovq_read", S_VALA, 64'h1234);
    expect_val("retired_1", S_RET, 64'd1);
    expect_val("popq_dstE", S_DSTE, 64'h4);
    expect_val("popq_dstM", S_DSTM, 64'h4);
    tick();

    // cmovXX not taken
    srcB = 4'h4;
    drive(1'b1, 4'h2, 4'hF, 4'h3, 1'b0, 64'd7, 64'd0);
    expect_val("popq_collision", S_VALB, 64'hBEEF);
    expect_val("retired_2", S_RET, 64'd2);
    expect_val("cmov_nt_dstE", S_DSTE, 64'hF);
    expect_val("cmov_nt_dstM", S_DSTM, 64'hF);
    tick();

    // cmovXX taken
    srcA = 4'h3;
    drive(1'b1, 4'h2, 4'hF, 4'h3, 1'b1, 64'd7, 64'd0);
    expect_val("cmov_nt_reg3", S_VALA, 64'd0);
    expect_val("retired_3", S_RET, 64'd3);
    expect_val("cmov_t_dstE", S_DSTE, 64'h3);
    tick();

    // mrmovq into reg 6
    drive(1'b1, 4'h5, 4'h6, 4'h1, 1'b0, 64'h99, 64'h55);
    expect_val("cmov_t_reg3", S_VALA, 64'd7);
    expect_val("mrmovq_dstE", S_DSTE, 64'hF);
    expect_val("mrmovq_dstM", S_DSTM, 64'h6);
    tick();

    // wb_valid low: dst still decoded, nothing committed
    srcA = 4'h6;
    drive(1'b0, 4'h3, 4'hF, 4'h7, 1'b0, 64'h77, 64'd0);
    expect_val("mrmovq_reg6", S_VALA, 64'h55);
    expect_val("idle_dstE", S_DSTE, 64'h7);
    tick();

    // irmovq with rB = RNONE: counted, not written
    srcB = 4'h7;
    drive(1'b1, 4'h3, 4'hF, 4'hF, 1'b0, 64'h5, 64'd0);
    expect_val("idle_reg7", S_VALB, 64'd0);
    expect_val("idle_retired", S_RET, 64'd5);
    tick();

    // pushq: E goes to %rsp
    drive(1'b1, 4'hA, 4'h1, 4'hF, 1'b0, 64'h200, 64'd0);
    expect_val("rnone_dst_retired", S_RET, 64'd6);
    expect_val("pushq_dstE", S_DSTE, 64'h4);
    expect_val("pushq_dstM", S_DSTM, 64'hF);
    tick();

    // halt
    srcA = 4'h4;
    drive(1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'd0);
    expect_val("pushq_rsp", S_VALA, 64'h200);
    expect_val("pre_halt_halted", S_HALT, 64'd0);
    expect_val("halt_dstE", S_DSTE, 64'hF);
    tick();

    // OPq while halted must be ignored
    drive(1'b1, 4'h6, 4'hF, 4'h1, 1'b0, 64'd9, 64'd0);
    expect_val("halt_halted", S_HALT, 64'd1);
    expect_val("halt_retired", S_RET, 64'd8);
    tick();

    // reset wins over a simultaneous commit
    srcA = 4'h1;
    rst = 1'b1;
    drive(1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'd11, 64'd0);
    expect_val("halted_no_write", S_VALA, 64'd0);
    expect_val("halted_frozen", S_RET, 64'd8);
    expect_val("halted_stays", S_HALT, 64'd1);
    tick();

    // invalid icode 0xD
    rst = 1'b0; srcB = 4'h2;
    drive(1'b1, 4'hD, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
    expect_val("rst_halted", S_HALT, 64'd0);
    expect_val("rst_retired", S_RET, 64'd0);
    expect_val("rst_over_commit", S_VALA, 64'd0);
    expect_val("rst_clears_reg2", S_VALB, 64'd0);
    tick();

    wb_valid = 1'b0;
    expect_val("invalid_halted", S_HALT, 64'd1);
    expect_val("invalid_not_counted", S_RET, 64'd0);
    tick();

    rst = 1'b1;
    tick();

    // OPq into reg 5 while reading reg 5 in the same cycle
    rst = 1'b0; srcA = 4'h5; srcB = 4'hF;
    drive(1'b1, 4'h6, 4'hF, 4'h5, 1'b0, 64'd42, 64'd0);
`ifdef WB_BYPASS_EN
    expect_val("bypass_same_cycle", S_VALA, 64'd42);
`else
    expect_val("no_bypass_same_cycle", S_VALA, 64'd0);
`endif
    expect_val("bypass_rnone", S_VALB, 64'd0);
    tick();

    wb_valid = 1'b0;
    expect_val("opq_next_cycle", S_VALA, 64'd42);
    expect_val("opq_retired", S_RET, 64'd1);
    tick();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
